// File: rtl/seq_divider.sv
// seq_divider: iterative unsigned restoring divider, one quotient bit per clock.
// Computes quotient and remainder of two N-bit operands with a start/done
// handshake; intended to undo or cross-check results of the N-bit array
// multiplier.
//
// Ports:
//   clk         - system clock, all state updates on the rising edge
//   rst         - synchronous, active-high reset
//   start       - request a division; honoured only when not busy
//   dividend    - unsigned dividend, sampled on the accepting edge
//   divisor     - unsigned divisor, sampled on the accepting edge
//   busy        - high while an iteration is in progress
//   done        - one-cycle pulse, results valid in this cycle
//   quotient    - registered quotient, held until the next completion
//   remainder   - registered remainder, held until the next completion
//   div_by_zero - set with done when the sampled divisor was 0, held
module seq_divider #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] dividend,
   input  logic [N-1:0] divisor,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] quotient,
   output logic [N-1:0] remainder,
   output logic         div_by_zero
);

   localparam int CW = $clog2(N + 1);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   state_t         state_q, state_d;
   logic [N:0]     r_q, r_d;       // partial remainder
   logic [N-1:0]   q_q, q_d;       // dividend shifting out / quotient shifting in
   logic [N-1:0]   d_q, d_d;       // captured divisor
   logic [CW-1:0]  cnt_q, cnt_d;   // completed steps
   logic           dz_q, dz_d;     // captured divisor was zero
   logic [N-1:0]   quot_q, quot_d;
   logic [N-1:0]   rem_q, rem_d;
   logic           dzo_q, dzo_d;

   logic [N:0]     r_sh;
   logic [N-1:0]   q_sh;
   logic [N:0]     t;
   logic [N:0]     r_new;
   logic [N-1:0]   q_new;
   logic           accept;

   // One restoring step: shift {R,Q} left, trial-subtract the divisor.
   always_comb begin
      r_sh = {r_q[N-1:0], q_q[N-1]};
      q_sh = {q_q[N-2:0], 1'b0};
      t    = r_sh - {1'b0, d_q};
      if (!t[N]) begin
         r_new = t;
         q_new = q_sh | {{(N-1){1'b0}}, 1'b1};
      end else begin
         r_new = r_sh;
         q_new = q_sh;
      end
   end

   always_comb begin
      state_d = state_q;
      r_d     = r_q;
      q_d     = q_q;
      d_d     = d_q;
      cnt_d   = cnt_q;
      dz_d    = dz_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      dzo_d   = dzo_q;
      accept  = start && (state_q == IDLE || state_q == DONE);

      case (state_q)
         IDLE: ;
         DONE: state_d = IDLE;
         CALC: begin
            if (dz_q) begin
               // Zero divisor spends a single CALC cycle so done lands one
               // edge after acceptance plus one, like a one-step division.
               state_d = DONE;
               quot_d  = '1;
               rem_d   = q_q;
               dzo_d   = 1'b1;
            end else begin
               r_d   = r_new;
               q_d   = q_new;
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == CW'(N - 1)) begin
                  state_d = DONE;
                  quot_d  = q_new;
                  rem_d   = r_new[N-1:0];
                  dzo_d   = 1'b0;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (accept) begin
         state_d = CALC;
         r_d     = '0;
         q_d     = dividend;
         d_d     = divisor;
         cnt_d   = '0;
         dz_d    = (divisor == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         r_q     <= '0;
         q_q     <= '0;
         d_q     <= '0;
         cnt_q   <= '0;
         dz_q    <= 1'b0;
         quot_q  <= '0;
         rem_q   <= '0;
         dzo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         r_q     <= r_d;
         q_q     <= q_d;
         d_q     <= d_d;
         cnt_q   <= cnt_d;
         dz_q    <= dz_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         dzo_q   <= dzo_d;
      end
   end

   assign busy        = (state_q == CALC);
   assign done        = (state_q == DONE);
   assign quotient    = quot_q;
   assign remainder   = rem_q;
   assign div_by_zero = dzo_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider at N=8, plus an exhaustive N=4 sweep and
// random N=16 pairs against a behavioural reference.
module tb_seq_divider;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // N=8 instance
   logic       start8;
   logic [7:0] dividend8, divisor8, quotient8, remainder8;
   logic       busy8, done8, dz8;
   // N=4 instance
   logic       start4;
   logic [3:0] dividend4, divisor4, quotient4, remainder4;
   logic       busy4, done4, dz4;
   // N=16 instance
   logic        start16;
   logic [15:0] dividend16, divisor16, quotient16, remainder16;
   logic        busy16, done16, dz16;

   seq_divider #(.N(8)) u8 (
      .clk(clk), .rst(rst), .start(start8), .dividend(dividend8), .divisor(divisor8),
      .busy(busy8), .done(done8), .quotient(quotient8), .remainder(remainder8),
      .div_by_zero(dz8));
   seq_divider #(.N(4)) u4 (
      .clk(clk), .rst(rst), .start(start4), .dividend(dividend4), .divisor(divisor4),
      .busy(busy4), .done(done4), .quotient(quotient4), .remainder(remainder4),
      .div_by_zero(dz4));
   seq_divider #(.N(16)) u16 (
      .clk(clk), .rst(rst), .start(start16), .dividend(dividend16), .divisor(divisor16),
      .busy(busy16), .done(done16), .quotient(quotient16), .remainder(remainder16),
      .div_by_zero(dz16));

   int checks = 0;
   int errors = 0;

   // Last results expected to be held on the N=8 outputs.
   logic [7:0] prev_q, prev_r;
   logic       prev_dz;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // One N=8 division: checks hold-before-completion, latency, results,
   // busy/done exclusivity and the single-cycle done pulse.
   task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] eq,
                      input logic [7:0] er, input logic edz, input int lat, input string tag);
      int idx;
      idx = 0;
      @(negedge clk);
      dividend8 = a; divisor8 = b; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      dividend8 = 8'($urandom); divisor8 = 8'($urandom);
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (i == 1) begin
            chk({tag, " hold_q"}, quotient8, prev_q);
            chk({tag, " hold_r"}, remainder8, prev_r);
            chk({tag, " hold_dz"}, dz8, prev_dz);
            chk({tag, " busy"}, busy8, 1'b1);
         end
         if (done8) begin
            idx = i;
            break;
         end
      end
      chk({tag, " latency"}, idx, lat + 1);
      chk({tag, " quotient"}, quotient8, eq);
      chk({tag, " remainder"}, remainder8, er);
      chk({tag, " dz"}, dz8, edz);
      chk({tag, " busy_at_done"}, busy8, 1'b0);
      prev_q = eq; prev_r = er; prev_dz = edz;
      @(negedge clk);
      chk({tag, " done_pulse"}, done8, 1'b0);
   endtask

   task automatic run4(input logic [3:0] a, input logic [3:0] b);
      logic [3:0] eq, er;
      logic edz;
      int seen;
      if (b == 0) begin eq = 4'hF; er = a; edz = 1'b1; end
      else begin eq = a / b; er = a % b; edz = 1'b0; end
      seen = 0;
      @(negedge clk);
      dividend4 = a; divisor4 = b; start4 = 1'b1;
      @(posedge clk); #1;
      start4 = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (done4) begin seen = i; break; end
      end
      chk($sformatf("n4 %0d/%0d", a, b), {seen, quotient4, remainder4, dz4},
          {((b == 0) ? 2 : 5), eq, er, edz});
   endtask

   task automatic run16(input logic [15:0] a, input logic [15:0] b);
      logic [15:0] eq, er;
      logic edz;
      int seen;
      if (b == 0) begin eq = 16'hFFFF; er = a; edz = 1'b1; end
      else begin eq = a / b; er = a % b; edz = 1'b0; end
      seen = 0;
      @(negedge clk);
      dividend16 = a; divisor16 = b; start16 = 1'b1;
      @(posedge clk); #1;
      start16 = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (done16) begin seen = i; break; end
      end
      chk($sformatf("n16 %0d/%0d", a, b), {seen, quotient16, remainder16, dz16},
          {((b == 0) ? 2 : 17), eq, er, edz});
   endtask

   initial begin
      int ndone, idx;
      logic [7:0] gq, gr;
      logic gdz;

      rst = 1'b1;
      start8 = 0; dividend8 = 0; divisor8 = 0;
      start4 = 0; dividend4 = 0; divisor4 = 0;
      start16 = 0; dividend16 = 0; divisor16 = 0;
      prev_q = 0; prev_r = 0; prev_dz = 0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset", {busy8, done8, quotient8, remainder8, dz8}, 19'd0);

      // Basic and boundary divisions
      op8(8'd100, 8'd7,   8'd14,  8'd2,  1'b0, 8, "t1 100/7");
      op8(8'd255, 8'd1,   8'd255, 8'd0,  1'b0, 8, "t2 255/1");
      op8(8'd5,   8'd9,   8'd0,   8'd5,  1'b0, 8, "t2 5/9");
      op8(8'd255, 8'd255, 8'd1,   8'd0,  1'b0, 8, "t2 255/255");
      op8(8'd37,  8'd0,   8'd255, 8'd37, 1'b1, 1, "t3 37/0");
      op8(8'd20,  8'd3,   8'd6,   8'd2,  1'b0, 8, "t3 20/3");

      // start while busy is ignored
      @(negedge clk);
      dividend8 = 8'd200; divisor8 = 8'd9; start8 = 1'b1;
      @(posedge clk); #1 start8 = 1'b0;
      repeat (2) @(negedge clk);
      dividend8 = 8'd50; divisor8 = 8'd5; start8 = 1'b1;
      @(posedge clk); #1 start8 = 1'b0;
      ndone = 0; gq = 0; gr = 0; gdz = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("t4 busy_done_excl", busy8 & done8, 1'b0);
         if (done8) begin
            ndone++; gq = quotient8; gr = remainder8; gdz = dz8;
         end
      end
      chk("t4 done_count", ndone, 1);
      chk("t4 result", {gq, gr, gdz}, {8'd22, 8'd2, 1'b0});
      chk("t4 busy_after", busy8, 1'b0);
      prev_q = 8'd22; prev_r = 8'd2; prev_dz = 1'b0;

      // Reset aborts a division in progress
      @(negedge clk);
      dividend8 = 8'd200; divisor8 = 8'd9; start8 = 1'b1;
      @(posedge clk); #1 start8 = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("t5 after_reset", {busy8, done8, quotient8, remainder8, dz8}, 19'd0);
      ndone = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (done8) ndone++;
      end
      chk("t5 no_done", ndone, 0);
      prev_q = 0; prev_r = 0; prev_dz = 0;
      op8(8'd9, 8'd4, 8'd2, 8'd1, 1'b0, 8, "t5 9/4");

      // Back-to-back: next start presented in the DONE cycle
      @(negedge clk);
      dividend8 = 8'd100; divisor8 = 8'd7; start8 = 1'b1;
      @(posedge clk); #1 start8 = 1'b0;
      idx = 0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (done8) begin idx = i; break; end
      end
      chk("t6 first_latency", idx, 9);
      chk("t6 first_result", {quotient8, remainder8, dz8}, {8'd14, 8'd2, 1'b0});
      dividend8 = 8'd20; divisor8 = 8'd3; start8 = 1'b1;
      @(posedge clk); #1 start8 = 1'b0;
      idx = 0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (i == 1) chk("t6 busy_after_b2b", {busy8, done8}, 2'b10);
         if (done8) begin idx = i; break; end
      end
      chk("t6 second_latency", idx, 9);
      chk("t6 second_result", {quotient8, remainder8, dz8}, {8'd6, 8'd2, 1'b0});

      // Exhaustive N=4
      for (int a = 0; a < 16; a++)
         for (int b = 0; b < 16; b++)
            run4(4'(a), 4'(b));

      // Random N=16, with occasional zero divisors
      for (int i = 0; i < 60; i++)
         run16(16'($urandom), (i % 10 == 0) ? 16'd0 : 16'($urandom));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
